// File: rtl/uart_pkg.sv
// uart_pkg: shared UART widths and 50 MHz 16x-oversample divisor pairs (int, frac/16)
package uart_pkg;
  localparam int DIV_W_DEF = 16;
  localparam int FRAC_W_DEF = 4;
  localparam int OVERSAMPLE_DEF = 16;
  typedef struct packed {
    logic [15:0] div_int;
    logic [3:0]  div_frac;
  } baud_div_t;
  localparam baud_div_t BAUD_9600   = '{16'd325, 4'd8};
  localparam baud_div_t BAUD_19200  = '{16'd162, 4'd12};
  localparam baud_div_t BAUD_38400  = '{16'd81, 4'd6};
  localparam baud_div_t BAUD_57600  = '{16'd54, 4'd4};
  localparam baud_div_t BAUD_115200 = '{16'd27, 4'd2};
endpackage

// File: rtl/frac_period_counter.sv
// frac_period_counter: fractional down-counter with shadowed divisor; in clk/rst/en_i/resync_i/div_*_i, out boundary_o
module frac_period_counter import uart_pkg::*; #(
  parameter int DIV_W = DIV_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int DEFAULT_DIV_INT = 27,
  parameter int DEFAULT_DIV_FRAC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              resync_i,
  input  logic              div_load_i,
  input  logic [DIV_W-1:0]  div_int_i,
  input  logic [FRAC_W-1:0] div_frac_i,
  output logic              boundary_o
);
  logic [DIV_W-1:0] cnt_q, cnt_d, act_int_q, act_int_d, sh_int_q, sh_int_d;
  logic [FRAC_W-1:0] acc_q, acc_d, act_frac_q, act_frac_d, sh_frac_q, sh_frac_d;
  logic pend_q, pend_d, restart;
  logic [FRAC_W:0] sum;
  function automatic logic [DIV_W-1:0] first_cnt(input logic [DIV_W-1:0] d);
    return (d == '0) ? '0 : d - DIV_W'(1);
  endfunction
  assign restart = ~en_i | resync_i;
  assign boundary_o = ~restart & (cnt_q == '0) & (act_int_q != '0);
  assign sum = {1'b0, acc_q} + {1'b0, act_frac_q};
  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    act_int_d = act_int_q;
    act_frac_d = act_frac_q;
    sh_int_d = sh_int_q;
    sh_frac_d = sh_frac_q;
    pend_d = pend_q;
    if (~en_i & div_load_i) begin
      act_int_d = div_int_i;
      act_frac_d = div_frac_i;
      sh_int_d = div_int_i;
      sh_frac_d = div_frac_i;
      pend_d = 1'b0;
      cnt_d = first_cnt(div_int_i);
      acc_d = '0;
    end else begin
      if (pend_q & en_i & (resync_i | cnt_q == '0)) begin
        act_int_d = sh_int_q;
        act_frac_d = sh_frac_q;
        pend_d = 1'b0;
        cnt_d = first_cnt(sh_int_q);
        acc_d = '0;
      end else if (restart) begin
        cnt_d = first_cnt(act_int_q);
        acc_d = '0;
      end else if (boundary_o) begin
        acc_d = sum[FRAC_W-1:0];
        cnt_d = act_int_q - DIV_W'(1) + DIV_W'(sum[FRAC_W]);
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - DIV_W'(1);
      end
      if (div_load_i) begin
        sh_int_d = div_int_i;
        sh_frac_d = div_frac_i;
        pend_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= DIV_W'(DEFAULT_DIV_INT - 1);
      acc_q <= '0;
      act_int_q <= DIV_W'(DEFAULT_DIV_INT);
      act_frac_q <= FRAC_W'(DEFAULT_DIV_FRAC);
      sh_int_q <= DIV_W'(DEFAULT_DIV_INT);
      sh_frac_q <= FRAC_W'(DEFAULT_DIV_FRAC);
      pend_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      act_int_q <= act_int_d;
      act_frac_q <= act_frac_d;
      sh_int_q <= sh_int_d;
      sh_frac_q <= sh_frac_d;
      pend_q <= pend_d;
    end
  end
endmodule

// File: rtl/baud_gen_frac.sv
// baud_gen_frac: fractional baud generator; in clk/rst/en/div_int/div_frac/div_load/resync, out os_tick/baud_tick/mid_tick
module baud_gen_frac import uart_pkg::*; #(
  parameter int DIV_W = DIV_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DEFAULT_DIV_INT = 27,
  parameter int DEFAULT_DIV_FRAC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  input  logic              resync,
  output logic              os_tick,
  output logic              baud_tick,
  output logic              mid_tick
);
  localparam int OS_W = $clog2(OVERSAMPLE);
  logic [OS_W-1:0] os_cnt_q, os_cnt_d;
  logic boundary, os_d, baud_d, mid_d;
  frac_period_counter #(
    .DIV_W(DIV_W),
    .FRAC_W(FRAC_W),
    .DEFAULT_DIV_INT(DEFAULT_DIV_INT),
    .DEFAULT_DIV_FRAC(DEFAULT_DIV_FRAC)
  ) u_cnt (
    .clk(clk),
    .rst(rst),
    .en_i(en),
    .resync_i(resync),
    .div_load_i(div_load),
    .div_int_i(div_int),
    .div_frac_i(div_frac),
    .boundary_o(boundary)
  );
  always_comb begin
    os_cnt_d = (~en | resync) ? '0 : boundary ? os_cnt_q + OS_W'(1) : os_cnt_q;
    os_d = boundary;
    baud_d = boundary & (os_cnt_q == OS_W'(OVERSAMPLE - 1));
    mid_d = boundary & (os_cnt_q == OS_W'(OVERSAMPLE / 2 - 1));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      os_cnt_q <= '0;
      os_tick <= 1'b0;
      baud_tick <= 1'b0;
      mid_tick <= 1'b0;
    end else begin
      os_cnt_q <= os_cnt_d;
      os_tick <= os_d;
      baud_tick <= baud_d;
      mid_tick <= mid_d;
    end
  end
endmodule

// File: doc/baud_gen_frac.md
Name: baud_gen_frac

Overview:
Parametrised successor to the fixed-divisor baud tick generator. It produces an oversample tick (os_tick), a bit-rate tick (baud_tick) and a mid-bit sample strobe (mid_tick). The divisor has integer and fractional parts and can be reloaded at run time. It feeds both the UART transmitter (baud_tick) and the receiver (os_tick/mid_tick, with resync aligned to the start bit).

Parameters:
DIV_W, 16, width of integer divisor (clk cycles per os_tick)
FRAC_W, 4, width of fractional divisor; average period = div_int + div_frac/2^FRAC_W
OVERSAMPLE, 16, os_ticks per baud_tick; power of two, >= 2
DEFAULT_DIV_INT, 27, active integer divisor after reset (50 MHz, 115200 baud, 16x)
DEFAULT_DIV_FRAC, 2, active fractional divisor after reset

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
en  in  1  generator enable; low holds all counters at their start values
div_int  in  DIV_W  new integer divisor
div_frac  in  FRAC_W  new fractional divisor
div_load  in  1  one-cycle strobe; captures div_int/div_frac into shadow registers
resync  in  1  one-cycle strobe; restarts the bit period (receiver start-bit edge)
os_tick  out  1  one-cycle pulse per oversample period
baud_tick  out  1  one-cycle pulse every OVERSAMPLE os_ticks
mid_tick  out  1  one-cycle pulse at os count OVERSAMPLE/2-1 (bit centre)

Behaviour:
- One clock domain. Reset is synchronous, active-high, sampled on the rising clk edge. All outputs are registered.
- Reset: active divisor = DEFAULT_*; shadow = DEFAULT_*; pend = 0; cnt = DEFAULT_DIV_INT-1; frac_acc = 0; os_cnt = 0; os_tick, baud_tick and mid_tick = 0.
- Down-counter cnt, when en=1:
  - cnt != 0: cnt decrements; all ticks 0.
  - cnt == 0 (boundary): os_tick <= 1. Then {carry, frac_acc} <= frac_acc + div_frac_active, and cnt <= div_int_active + carry - 1.
- First os_tick is asserted exactly div_int_active cycles after the first enabled edge. Steady-state period is div_int or div_int+1 cycles. Average over 2^FRAC_W periods is exact.
- os_cnt increments modulo OVERSAMPLE on each boundary.
  - baud_tick <= 1 together with the os_tick whose boundary wraps os_cnt from OVERSAMPLE-1 to 0.
  - mid_tick <= 1 together with the os_tick at which os_cnt == OVERSAMPLE/2-1 before the increment.
- div_load: the shadow captures inputs and pend is set. At the next boundary the active divisor <= shadow, frac_acc <= 0, pend <= 0, and the new divisor sets the next period. The current period is never truncated or stretched.
- div_load and a boundary in the same cycle: the boundary uses the old shadow; the new value applies at the following boundary.
- div_load while en=0: applies immediately (active <= inputs, cnt <= div_int-1).
- div_int_active == 0: generator halts. No ticks, cnt held at 0, frac_acc held. Resumes at the next div_load with a nonzero value.
- div_int_active == 1 with frac 0: os_tick is high every cycle.
- resync (en=1): cnt <= div_int_active-1, frac_acc <= 0, os_cnt <= 0, ticks 0 that cycle. A pending load is applied at the same time.
- resync has priority over a coincident boundary. div_load in the same cycle as resync is captured into the shadow and applies at the next boundary.
- en=0: same register effect as resync, held each cycle; ticks 0. The shadow and pend are retained.
- rst has priority over every other input at any point, including mid-period.

Decomposition:
- Shared package uart_pkg: DIV_W/FRAC_W/OVERSAMPLE defaults, and div_int/div_frac pairs for standard baud rates at 50 MHz.
- One natural sub-module: frac_period_counter (cnt + frac_acc + shadow/pend logic, emits boundary). The top adds os_cnt and tick decode.

Test Plan:
- Reset then en=1, defaults (27, 2) -> first os_tick at cycle 27 after en; 16 periods total 27*16+2 = 434 cycles; baud_tick coincides with the 16th os_tick.
- div_load (4, 0) while en=0, then en=1 -> os_tick every 4 cycles; mid_tick on the 8th os_tick; baud_tick every 64 cycles.
- div_load (4, 8) with FRAC_W=4 -> periods alternate 4,5,4,5...; 16 os periods total 72 cycles.
- div_load (10, 0) mid-period of a running (4, 0) count -> the current period completes at 4 cycles; the next period is 10 cycles; no tick is lost or doubled.
- resync asserted 2 cycles before a baud_tick -> no ticks that cycle; next os_tick div_int cycles later; mid_tick on the 8th os_tick after resync.
- div_load (0, 0) -> ticks stop; later div_load (3, 0) -> os_tick resumes 3 cycles after the load is applied. Also: rst asserted mid-period -> all outputs 0 next cycle and defaults restored.
